// File: rtl/mul_div_unit_pkg.sv
// mdu_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   XLEN / CNT_W  operand width and iteration counter width
//   mdu_op_e      funct3 encodings of the M-extension operations
//   mdu_state_e   sequencer states
//   negate        two's-complement negate helper used for magnitudes and sign fix
package mdu_pkg;

   localparam int XLEN  = 32;
   localparam int CNT_W = 6;

   typedef enum logic [2:0] {
      MDU_MUL    = 3'd0,
      MDU_MULH   = 3'd1,
      MDU_MULHSU = 3'd2,
      MDU_MULHU  = 3'd3,
      MDU_DIV    = 3'd4,
      MDU_DIVU   = 3'd5,
      MDU_REM    = 3'd6,
      MDU_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } mdu_state_e;

   function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] x);
      return ~x + XLEN'(1);
   endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: request/writeback bundle between the core datapath and the
// multiply/divide unit.
//   start, kill, op, rs1_data, rs2_data, rd_addr   core -> unit
//   busy, done, result, wb_addr, wb_en             unit -> core
// master = core side, slave = unit side.
interface mul_div_unit_if;
   import mdu_pkg::*;

   logic            start;
   logic            kill;
   logic [2:0]      op;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [4:0]      rd_addr;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      wb_addr;
   logic            wb_en;

   modport master (
      output start, kill, op, rs1_data, rs2_data, rd_addr,
      input  busy, done, result, wb_addr, wb_en
   );

   modport slave (
      input  start, kill, op, rs1_data, rs2_data, rd_addr,
      output busy, done, result, wb_addr, wb_en
   );

endinterface

// File: rtl/mul_div_unit_iter_step.sv
// mdu_iter_step: one combinational iteration of the shared hi/lo datapath.
//   is_div  1: restoring shift-subtract step, 0: shift-add step
//   hi, lo  current accumulator halves
//   m       multiplicand magnitude (multiply) or divisor magnitude (divide)
//   hi_nxt, lo_nxt  accumulator after this step
// Multiply: lo holds the unconsumed multiplier bits, the product shifts in from
// the top. Divide: hi is the partial remainder, lo shifts the dividend out and
// the quotient bits in.
module mdu_iter_step
   import mdu_pkg::*;
(
   input  logic            is_div,
   input  logic [XLEN-1:0] hi,
   input  logic [XLEN-1:0] lo,
   input  logic [XLEN-1:0] m,
   output logic [XLEN-1:0] hi_nxt,
   output logic [XLEN-1:0] lo_nxt
);

   logic [XLEN:0] sum;
   logic [XLEN:0] shifted;
   logic [XLEN:0] diff;

   always_comb begin
      sum     = {1'b0, hi} + {1'b0, (lo[0] ? m : '0)};
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, m};
      hi_nxt  = '0;
      lo_nxt  = '0;
      if (is_div) begin
         // borrow out of the 33-bit subtract means the trial remainder went negative
         if (diff[XLEN]) begin
            hi_nxt = shifted[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b0};
         end else begin
            hi_nxt = diff[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], 1'b1};
         end
      end else begin
         hi_nxt = sum[XLEN:1];
         lo_nxt = {sum[0], lo[XLEN-1:1]};
      end
   end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit, stalls the core via busy.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  start/kill/op/rs1_data/rs2_data/rd_addr in,
//                busy/done/result/wb_addr/wb_en out
//
// state   | meaning
// IDLE    | waiting for start; operands latched on accept
// CALC    | 32 shift-add / shift-subtract iterations on magnitudes
// FIX     | apply result sign, select word, load result
// DONE    | done pulse, writeback enable when wb_addr != 0
module mul_div_unit
   import mdu_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   mul_div_unit_if.slave  bus
);

   mdu_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]      op_q;
   logic [XLEN-1:0] hi_q;
   logic [XLEN-1:0] lo_q;
   logic [XLEN-1:0] m_q;
   logic            neg_q;
   logic            sp_q;
   logic            busy_q;
   logic            done_q;
   logic            wb_en_q;
   logic [XLEN-1:0] result_q;
   logic [4:0]      wb_addr_q;

   logic            signed_a;
   logic            signed_b;
   logic            neg_a;
   logic            neg_b;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic            is_div;
   logic            div_zero;
   logic            div_ovf;
   logic            special;
   logic [XLEN-1:0] sp_val;

   logic [XLEN-1:0]   hi_nxt;
   logic [XLEN-1:0]   lo_nxt;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_rem;
   logic [XLEN-1:0]   fix_val;

   // operand decode on the request, used only on the accepting edge
   always_comb begin
      signed_a = (bus.op == MDU_MULH) || (bus.op == MDU_MULHSU) ||
                 (bus.op == MDU_DIV)  || (bus.op == MDU_REM);
      signed_b = (bus.op == MDU_MULH) || (bus.op == MDU_DIV) || (bus.op == MDU_REM);
      neg_a    = signed_a & bus.rs1_data[XLEN-1];
      neg_b    = signed_b & bus.rs2_data[XLEN-1];
      mag_a    = neg_a ? negate(bus.rs1_data) : bus.rs1_data;
      mag_b    = neg_b ? negate(bus.rs2_data) : bus.rs2_data;
      is_div   = bus.op[2];
      div_zero = (bus.rs2_data == '0);
      div_ovf  = ((bus.op == MDU_DIV) || (bus.op == MDU_REM)) &&
                 (bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_data == '1);
      special  = is_div & (div_zero | div_ovf);
      sp_val   = '0;
      if (div_zero)
         sp_val = bus.op[1] ? bus.rs1_data : '1;
      else
         sp_val = bus.op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
   end

   mdu_iter_step u_step (
      .is_div (op_q[2]),
      .hi     (hi_q),
      .lo     (lo_q),
      .m      (m_q),
      .hi_nxt (hi_nxt),
      .lo_nxt (lo_nxt)
   );

   // sign fix: op_q[1] selects remainder (hi) for REM/REMU, quotient (lo) otherwise
   always_comb begin
      prod    = {hi_q, lo_q};
      prod_s  = neg_q ? (~prod + (2*XLEN)'(1)) : prod;
      quo_rem = op_q[1] ? hi_q : lo_q;
      fix_val = '0;
      if (op_q[2])
         fix_val = neg_q ? negate(quo_rem) : quo_rem;
      else if (op_q == MDU_MUL)
         fix_val = prod_s[XLEN-1:0];
      else
         fix_val = prod_s[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         op_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         m_q       <= '0;
         neg_q     <= 1'b0;
         sp_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         result_q  <= '0;
         wb_addr_q <= '0;
      end else if (bus.kill && (state_q != ST_IDLE)) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wb_en_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start && !bus.kill) begin
                  busy_q    <= 1'b1;
                  op_q      <= bus.op;
                  wb_addr_q <= bus.rd_addr;
                  cnt_q     <= CNT_W'(XLEN-1);
                  sp_q      <= special;
                  neg_q     <= (is_div && bus.op[1]) ? neg_a : (neg_a ^ neg_b);
                  hi_q      <= '0;
                  if (special) begin
                     lo_q    <= sp_val;
                     state_q <= ST_FIX;
                  end else begin
                     lo_q    <= is_div ? mag_a : mag_b;
                     m_q     <= is_div ? mag_b : mag_a;
                     state_q <= ST_CALC;
                  end
               end
            end
            ST_CALC: begin
               hi_q <= hi_nxt;
               lo_q <= lo_nxt;
               if (cnt_q == '0)
                  state_q <= ST_FIX;
               else
                  cnt_q <= cnt_q - CNT_W'(1);
            end
            ST_FIX: begin
               result_q <= sp_q ? lo_q : fix_val;
               done_q   <= 1'b1;
               wb_en_q  <= (wb_addr_q != '0);
               state_q  <= ST_DONE;
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               wb_en_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // kill suppresses a done pulse in the very cycle it is raised
   assign bus.busy    = busy_q;
   assign bus.done    = done_q & ~bus.kill;
   assign bus.wb_en   = wb_en_q & ~bus.kill;
   assign bus.result  = result_q;
   assign bus.wb_addr = wb_addr_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
   import mdu_pkg::*;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  addr;
      logic        en;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mul_div_unit_if bus();
   mul_div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   exp_t        scb[$];
   exp_t        mon_e;
   logic [31:0] last_res = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // reference: plain integer arithmetic following the RV32M rules
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sbv, ua;
      logic [63:0] p;
      int          ia, ib;
      logic [31:0] r;
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      ua  = longint'({32'b0, a});
      ia  = $signed(a);
      ib  = $signed(b);
      p   = '0;
      r   = '0;
      case (op)
         3'd0: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
         3'd1: begin p = sa * sbv; r = p[63:32]; end
         3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
         3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
         3'd4: begin
            if (b == 0) r = 32'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
            else r = ia / ib;
         end
         3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) r = a;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
            else r = ia % ib;
         end
         default: r = (b == 0) ? a : a % b;
      endcase
      if (ua < 0) r = '0;
      return r;
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
      if (op < 3'd4) return 1'b0;
      if (b == 0) return 1'b1;
      return ((op == 3'd4) || (op == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   endfunction

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (bus.busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (bus.busy) begin
         checks++;
         failures++;
         $display("FAIL idle_timeout actual=busy required=idle");
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
      exp_t e;
      wait_idle();
      bus.start    = 1'b1;
      bus.op       = op;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.rd_addr  = rd;
      e.res  = ref_model(op, a, b);
      e.addr = rd;
      e.en   = (rd != 0);
      e.cyc  = cyc + (is_special(op, a, b) ? 2 : 34);
      scb.push_back(e);
      @(negedge clk);
      bus.start    = 1'b0;
      bus.op       = 3'($urandom);
      bus.rs1_data = $urandom;
      bus.rs2_data = $urandom;
      bus.rd_addr  = 5'($urandom);
      chk("busy_after_accept", 32'(bus.busy), 32'd1);
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.done) begin
            if (scb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 required=0");
            end else begin
               mon_e = scb.pop_front();
               chk("result", bus.result, mon_e.res);
               chk("wb_addr", 32'(bus.wb_addr), 32'(mon_e.addr));
               chk("wb_en", 32'(bus.wb_en), 32'(mon_e.en));
               chk("latency", 32'(cyc), 32'(mon_e.cyc));
               last_res = mon_e.res;
            end
         end else begin
            if (bus.wb_en) begin
               checks++;
               failures++;
               $display("FAIL wb_en_without_done actual=1 required=0");
            end
            if (scb.size() > 0 && cyc > scb[0].cyc) begin
               checks++;
               failures++;
               $display("FAIL missing_done actual=none required=cycle_%0d", scb[0].cyc);
               void'(scb.pop_front());
            end
         end
      end
   end

   initial begin
      bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0;
      bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_addr = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_wb_addr", 32'(bus.wb_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", 32'(bus.busy), 32'd0);
      chk("post_rst_wb_en", 32'(bus.wb_en), 32'd0);

      // directed cases
      issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
      issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
      issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
      issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3);
      issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
      issue(3'd5, 32'd100, 32'd0, 5'd6);
      issue(3'd6, 32'd13, 32'd0, 5'd7);
      issue(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8);
      issue(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd10);
      issue(3'd7, 32'hFFFF_FFFF, 32'd10, 5'd11);

      // start while busy is ignored; rd=0 still completes without writeback
      issue(3'd0, 32'h1234_5678, 32'h0000_0010, 5'd0);
      repeat (9) @(negedge clk);
      bus.start = 1'b1; bus.op = 3'd5; bus.rs1_data = 32'd50; bus.rs2_data = 32'd0; bus.rd_addr = 5'd9;
      @(negedge clk);
      bus.start = 1'b0;

      // asynchronous reset mid-operation
      issue(3'd1, $urandom, $urandom, 5'd12);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      #1;
      scb.delete();
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_done", 32'(bus.done), 32'd0);
      chk("midrst_result", bus.result, 32'd0);
      chk("midrst_wb_addr", 32'(bus.wb_addr), 32'd0);
      last_res = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      // kill during CALC: back to IDLE, result kept
      issue(3'd0, 32'd3, 32'd5, 5'd13);
      wait_idle();
      issue(3'd4, 32'd1000, 32'd7, 5'd14);
      repeat (19) @(negedge clk);
      bus.kill = 1'b1;
      scb.delete();
      @(negedge clk);
      bus.kill = 1'b0;
      chk("kill_busy", 32'(bus.busy), 32'd0);
      chk("kill_result_held", bus.result, last_res);
      repeat (40) @(negedge clk);

      // start and kill together in IDLE: kill wins
      bus.start = 1'b1; bus.kill = 1'b1; bus.op = 3'd0;
      @(negedge clk);
      bus.start = 1'b0; bus.kill = 1'b0;
      chk("kill_start_idle_busy", 32'(bus.busy), 32'd0);

      // kill during the DONE cycle suppresses the pulse
      issue(3'd5, 32'd9, 32'd0, 5'd15);
      @(posedge clk);
      #1 bus.kill = 1'b1;
      scb.delete();
      @(posedge clk);
      #1 bus.kill = 1'b0;
      repeat (5) @(negedge clk);

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         int          sel;
         op  = 3'($urandom_range(0, 7));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel == 2) b = $urandom_range(1, 20);
         else if (sel == 3) begin a = $urandom_range(0, 300); b = $urandom_range(0, 300); end
         issue(op, a, b, 5'($urandom_range(0, 31)));
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      begin
         int n = 0;
         while (scb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
         end
      end
      repeat (40) @(negedge clk);
      if (scb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain actual=%0d required=0", scb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
